// File: rtl/keypad_entry.sv
// Keypad front end: debounces the scanner's key lines, turns each press into one
// event and builds a 4-digit BCD entry for the display. Build option: KEYPAD_ENTRY_BKSP_EN.
module keypad_entry #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [9:0]  numbers,
  input  logic        asterisk,
  input  logic        hash,
  output logic [15:0] hexx,
  output logic [3:0]  mask,
  output logic [3:0]  points,
  output logic [15:0] value,
  output logic        valid,
  output logic [3:0]  key_code,
  output logic        key_strobe,
  output logic        full
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DEB  = 2'd1;
  localparam logic [1:0] S_HELD = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;
  localparam logic [3:0] NONE   = 4'hF;
  // The first matching sample is taken on entry with cnt=0, so the
  // DEBOUNCE-th sample is the one seen while cnt holds DEBOUNCE-2.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 2);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       count_q, count_d;
  logic [15:0]      hexx_q, hexx_d;
  logic [15:0]      value_q, value_d;
  logic             valid_q, valid_d;
  logic [3:0]       key_code_q;
  logic             key_strobe_q;
  logic [3:0]       code;
  logic [3:0]       hits;
  logic [11:0]      lines;
  logic             fire;

  // One-hot decode; no key or several keys both map to NONE.
  always_comb begin
    lines = {hash, asterisk, numbers};
    code  = NONE;
    hits  = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (lines[i]) begin
        hits = hits + 4'd1;
        code = 4'(i);
      end
    end
    if (hits != 4'd1) code = NONE;
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    case (state_q)
      S_IDLE: if (code != NONE) begin
        state_d = S_DEB;
        cand_d  = code;
        cnt_d   = '0;
      end
      S_DEB: if (code == cand_q) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_HELD;
          fire    = en;
        end
      end else begin
        state_d = S_IDLE;
      end
      S_HELD: if (code == NONE) begin
        state_d = S_REL;
        cnt_d   = '0;
      end
      default: if (code == NONE) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_IDLE;
      end else begin
        state_d = S_HELD;
      end
    endcase
  end

  always_comb begin
    hexx_d  = hexx_q;
    count_d = count_q;
    value_d = value_q;
    valid_d = 1'b0;
    if (fire) begin
      if (cand_q < 4'd10) begin
        if (count_q != 3'd4) begin
          hexx_d  = {hexx_q[11:0], cand_q};
          count_d = count_q + 3'd1;
        end
      end else if (cand_q == 4'd11) begin
        if (count_q != 3'd0) begin
          value_d = hexx_q;
          valid_d = 1'b1;
          hexx_d  = '0;
          count_d = 3'd0;
        end
      end else begin
`ifdef KEYPAD_ENTRY_BKSP_EN
        if (count_q != 3'd0) begin
          hexx_d  = {4'h0, hexx_q[15:4]};
          count_d = count_q - 3'd1;
        end
`else
        hexx_d  = '0;
        count_d = 3'd0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cand_q       <= '0;
      cnt_q        <= '0;
      count_q      <= '0;
      hexx_q       <= '0;
      value_q      <= '0;
      valid_q      <= 1'b0;
      key_code_q   <= '0;
      key_strobe_q <= 1'b0;
    end else begin
      // Pulses drop on the next edge even when en is low.
      valid_q      <= valid_d;
      key_strobe_q <= fire;
      if (fire) key_code_q <= cand_q;
      if (en) begin
        state_q <= state_d;
        cand_q  <= cand_d;
        cnt_q   <= cnt_d;
        count_q <= count_d;
        hexx_q  <= hexx_d;
        value_q <= value_d;
      end
    end
  end

  always_comb begin
    case (count_q)
      3'd2:    mask = 4'b0011;
      3'd3:    mask = 4'b0111;
      3'd4:    mask = 4'b1111;
      default: mask = 4'b0001;
    endcase
  end

  assign hexx       = hexx_q;
  assign points     = {3'b000, (state_q == S_HELD) || (state_q == S_REL)};
  assign value      = value_q;
  assign valid      = valid_q;
  assign key_code   = key_code_q;
  assign key_strobe = key_strobe_q;
  assign full       = (count_q == 3'd4);

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed scenarios plus random press/release traffic,
// every cycle compared against a run-length model of debounce and a digit queue.
module tb_keypad_entry;
  localparam int DEB = 4;

  logic        clk, rst_n, en;
  logic [9:0]  numbers;
  logic        asterisk, hash;
  logic [15:0] hexx, value;
  logic [3:0]  mask, points, key_code;
  logic        valid, key_strobe, full;

  int errors = 0;
  int checks = 0;
  int dut_strobes = 0;

  keypad_entry #(.DEBOUNCE(DEB), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .numbers(numbers), .asterisk(asterisk),
    .hash(hash), .hexx(hexx), .mask(mask), .points(points), .value(value),
    .valid(valid), .key_code(key_code), .key_strobe(key_strobe), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a press is accepted after DEB consecutive enabled samples
  // of one key while armed; re-arming needs DEB consecutive no-key samples.
  logic [3:0]  digs[$];
  bit          armed;
  int          run_code, run_len, none_run;
  logic [15:0] m_value;
  logic [3:0]  m_key_code;
  logic        m_strobe, m_valid;

  function automatic logic [11:0] key(input int k);
    logic [11:0] one;
    one = 12'd1;
    return one << k;
  endfunction

  function automatic int decode(input logic [11:0] ln);
    int n, c;
    n = 0; c = -1;
    for (int i = 0; i < 12; i++) if (ln[i]) begin n++; c = i; end
    return (n == 1) ? c : -1;
  endfunction

  function automatic logic [15:0] m_hexx();
    logic [15:0] h;
    h = 16'h0;
    for (int i = 0; i < digs.size(); i++) h = h + (16'(digs[digs.size()-1-i]) << (4*i));
    return h;
  endfunction

  function automatic logic [3:0] m_mask();
    case (digs.size())
      2: return 4'b0011;
      3: return 4'b0111;
      4: return 4'b1111;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic model_reset();
    digs.delete();
    armed = 1; run_code = -1; run_len = 0; none_run = 0;
    m_value = 16'h0; m_key_code = 4'h0; m_strobe = 0; m_valid = 0;
  endtask

  task automatic accept(input int c);
    m_key_code = 4'(c);
    m_strobe = 1;
    if (c < 10) begin
      if (digs.size() < 4) digs.push_back(4'(c));
    end else if (c == 11) begin
      if (digs.size() > 0) begin
        m_value = m_hexx(); m_valid = 1; digs.delete();
      end
    end else begin
`ifdef KEYPAD_ENTRY_BKSP_EN
      if (digs.size() > 0) void'(digs.pop_back());
`else
      digs.delete();
`endif
    end
  endtask

  task automatic model_step(input logic [11:0] ln, input logic e);
    int c;
    m_strobe = 0; m_valid = 0;
    if (!e) return;
    c = decode(ln);
    if (c < 0) begin
      run_len = 0;
      none_run++;
      if (!armed && none_run >= DEB) armed = 1;
    end else begin
      none_run = 0;
      if (armed) begin
        if (run_len > 0 && c == run_code) run_len++;
        else begin run_code = c; run_len = 1; end
        if (run_len == DEB) begin
          accept(c); armed = 0; run_len = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("hexx", hexx, m_hexx());
    chk("mask", 16'(mask), 16'(m_mask()));
    chk("points", 16'(points), {15'h0, !armed});
    chk("value", value, m_value);
    chk("valid", 16'(valid), 16'(m_valid));
    chk("key_code", 16'(key_code), 16'(m_key_code));
    chk("key_strobe", 16'(key_strobe), 16'(m_strobe));
    chk("full", 16'(full), 16'(digs.size() == 4));
  endtask

  task automatic check_reset_values();
    chk("rst_hexx", hexx, 16'h0);
    chk("rst_mask", 16'(mask), 16'h1);
    chk("rst_points", 16'(points), 16'h0);
    chk("rst_value", value, 16'h0);
    chk("rst_valid", 16'(valid), 16'h0);
    chk("rst_key_code", 16'(key_code), 16'h0);
    chk("rst_key_strobe", 16'(key_strobe), 16'h0);
    chk("rst_full", 16'(full), 16'h0);
  endtask

  task automatic step(input logic [11:0] ln, input logic e);
    numbers = ln[9:0]; asterisk = ln[10]; hash = ln[11]; en = e;
    @(posedge clk); #1;
    if (key_strobe === 1'b1) dut_strobes++;
    model_step(ln, e);
    check_all();
  endtask

  task automatic hold(input logic [11:0] ln, input int n);
    for (int i = 0; i < n; i++) step(ln, 1'b1);
  endtask

  task automatic press(input int k);
    hold(key(k), DEB);
    hold(12'h0, DEB);
  endtask

  initial begin
    int s0, k, a, b, len;
    logic [11:0] ln;
    rst_n = 1'b0; en = 1'b1; numbers = '0; asterisk = 1'b0; hash = 1'b0;
    model_reset();
    #1;
    check_reset_values();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Single press, then a too-short press.
    press(1);
    chk("p1_strobes", 16'(dut_strobes), 16'd1);
    chk("p1_hexx", hexx, 16'h0001);
    chk("p1_mask", 16'(mask), 16'h1);
    hold(key(2), DEB - 1);
    hold(12'h0, DEB);
    chk("short_strobes", 16'(dut_strobes), 16'd1);
    chk("short_hexx", hexx, 16'h0001);

    // Chatter, then a steady press that must strobe once only.
    for (int i = 0; i < 20; i++) step((i % 2 == 0) ? key(5) : 12'h0, 1'b1);
    chk("chatter_strobes", 16'(dut_strobes), 16'd1);
    hold(key(5), DEB + 6);
    chk("steady_strobes", 16'(dut_strobes), 16'd2);
    hold(12'h0, DEB);

    // Commit, then fill past four digits and commit again.
    press(11);
    chk("commit15", value, 16'h0015);
    for (int d = 1; d <= 5; d++) press(d);
    chk("fill_hexx", hexx, 16'h1234);
    chk("fill_full", 16'(full), 16'h1);
    chk("fill_mask", 16'(mask), 16'hF);
    s0 = dut_strobes;
    press(11);
    chk("c_value", value, 16'h1234);
    chk("c_hexx", hexx, 16'h0);
    chk("c_full", 16'(full), 16'h0);
    chk("c_strobes", 16'(dut_strobes - s0), 16'd1);

    // '#' on empty entry, then a two-key chord.
    press(11);
    chk("empty_hash_code", 16'(key_code), 16'd11);
    chk("empty_hash_value", value, 16'h1234);
    s0 = dut_strobes;
    hold(12'h003, 10);
    hold(12'h0, DEB);
    chk("chord_strobes", 16'(dut_strobes - s0), 16'd0);

    // Clear/backspace.
    press(7); press(8); press(10);
`ifdef KEYPAD_ENTRY_BKSP_EN
    chk("star_hexx", hexx, 16'h0007);
`else
    chk("star_hexx", hexx, 16'h0000);
`endif
    chk("star_mask", 16'(mask), 16'h1);

    // Freeze with en low, then async reset while held.
    hold(key(9), DEB);
    s0 = dut_strobes;
    for (int i = 0; i < 10; i++) step(key(9), 1'b0);
    hold(key(9), 2);
    chk("en_strobes", 16'(dut_strobes - s0), 16'd0);
    chk("held_points", 16'(points), 16'h1);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    s0 = dut_strobes;
    hold(key(9), DEB);
    chk("rearm_strobes", 16'(dut_strobes - s0), 16'd1);
    hold(12'h0, DEB + 2);

    // Random traffic; different keys are always split by an enabled no-key sample.
    for (int seg = 0; seg < 300; seg++) begin
      k = $urandom_range(0, 11);
      len = $urandom_range(1, DEB + 3);
      for (int i = 0; i < len; i++) step(key(k), ($urandom_range(0, 7) != 0));
      len = $urandom_range(1, DEB + 3);
      for (int i = 0; i < len; i++) begin
        ln = 12'h0;
        if ($urandom_range(0, 3) == 0) begin
          a = $urandom_range(0, 11);
          b = (a + $urandom_range(1, 11)) % 12;
          ln = key(a) | key(b);
        end
        step(ln, (i == 0) ? 1'b1 : ($urandom_range(0, 7) != 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
